// File: rtl/pn_correlator.sv
// PN correlator: despreads complex I/Q samples against a local PN chip stream.
// Each period of N = len+1 strobed chips is summed with saturation. The period
// sum is presented on sum_i_o/sum_q_o with a one-cycle valid_o pulse.
module pn_correlator #(
  parameter int width     = 16,
  parameter int acc_width = 32,
  parameter int len_width = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        ena_i,
  input  logic                        strobe_i,
  input  logic                        pn_i,
  input  logic        [len_width-1:0] len_i,
  input  logic signed [width-1:0]     i_i,
  input  logic signed [width-1:0]     q_i,
  output logic signed [acc_width-1:0] sum_i_o,
  output logic signed [acc_width-1:0] sum_q_o,
  output logic                        valid_o,
  output logic                        busy_o,
  output logic                        ovf_o
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [acc_width-1:0] ACC_MAX = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic [acc_width-1:0] ACC_MIN = {1'b1, {(acc_width-1){1'b0}}};

  // Saturating add of +/-sample into an accumulator; MSB of result flags clamping.
  // The sample is sign-extended before negation so the most negative sample
  // negates exactly in the wider accumulator.
  function automatic logic [acc_width:0] sat_add(
    input logic [acc_width-1:0] acc,
    input logic [width-1:0]     samp,
    input logic                 pn
  );
    logic [acc_width-1:0] ext;
    logic [acc_width-1:0] term;
    logic [acc_width:0]   sum;
    ext  = {{(acc_width-width){samp[width-1]}}, samp};
    term = pn ? ext : -ext;
    sum  = {acc[acc_width-1], acc} + {term[acc_width-1], term};
    if (sum[acc_width] != sum[acc_width-1])
      sat_add = {1'b1, (sum[acc_width] ? ACC_MIN : ACC_MAX)};
    else
      sat_add = {1'b0, sum[acc_width-1:0]};
  endfunction

  state_t               r_state;
  logic [acc_width-1:0] r_acc_i;
  logic [acc_width-1:0] r_acc_q;
  logic [len_width-1:0] r_cnt;
  logic [len_width-1:0] r_len;
  logic [acc_width-1:0] r_sum_i;
  logic [acc_width-1:0] r_sum_q;
  logic                 r_valid;
  logic                 r_ovf;

  logic [acc_width:0]   w_add_i;
  logic [acc_width:0]   w_add_q;
  logic [acc_width-1:0] w_new_i;
  logic [acc_width-1:0] w_new_q;
  logic                 w_sat;
  logic                 w_last;

  // Next accumulator values for the current chip and period-end detection.
  assign w_add_i = sat_add(r_acc_i, i_i, pn_i);
  assign w_add_q = sat_add(r_acc_q, q_i, pn_i);
  assign w_new_i = w_add_i[acc_width-1:0];
  assign w_new_q = w_add_q[acc_width-1:0];
  assign w_sat   = w_add_i[acc_width] | w_add_q[acc_width];
  assign w_last  = (r_cnt == r_len);

  // Control FSM, accumulators and registered outputs.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would make the order of lines matter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sum_i <= '0;
      r_sum_q <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!ena_i) begin
        // Disable discards the partial period and clears results and flag.
        r_state <= IDLE;
        r_acc_i <= '0;
        r_acc_q <= '0;
        r_cnt   <= '0;
        r_sum_i <= '0;
        r_sum_q <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            // Entry edge: start a fresh period; a strobe here is ignored.
            r_state <= ACCUM;
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
            r_len   <= len_i;
          end
          ACCUM: begin
            if (strobe_i) begin
              r_ovf <= r_ovf | w_sat;
              if (w_last) begin
                r_sum_i <= w_new_i;
                r_sum_q <= w_new_q;
                r_valid <= 1'b1;
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_cnt   <= '0;
                r_len   <= len_i;
              end else begin
                r_acc_i <= w_new_i;
                r_acc_q <= w_new_q;
                r_cnt   <= r_cnt + len_width'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sum_i_o = r_sum_i;
  assign sum_q_o = r_sum_q;
  assign valid_o = r_valid;
  assign busy_o  = (r_state == ACCUM);
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_pn_correlator.sv
// Directed bench for pn_correlator: expected period results are queued when the
// stimulus is issued and a monitor compares them against each valid_o pulse.
module tb_pn_correlator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ena;
  logic               ena_s;
  logic               strobe;
  logic               pn;
  logic        [15:0] len;
  logic signed [15:0] i_in;
  logic signed [15:0] q_in;

  logic signed [31:0] sum_i, sum_q;
  logic               valid, busy, ovf;
  logic signed [16:0] s_sum_i, s_sum_q;
  logic               s_valid, s_busy, s_ovf;

  typedef struct {
    longint si;
    longint sq;
    logic   ov;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pn_correlator dut (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .strobe_i(strobe), .pn_i(pn),
    .len_i(len), .i_i(i_in), .q_i(q_in),
    .sum_i_o(sum_i), .sum_q_o(sum_q), .valid_o(valid), .busy_o(busy), .ovf_o(ovf)
  );

  pn_correlator #(.width(16), .acc_width(17), .len_width(16)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena_s), .strobe_i(strobe), .pn_i(pn),
    .len_i(len), .i_i(i_in), .q_i(q_in),
    .sum_i_o(s_sum_i), .sum_q_o(s_sum_q), .valid_o(s_valid), .busy_o(s_busy),
    .ovf_o(s_ovf)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_main(input longint si, input longint sq, input logic ov);
    exp_t e;
    e.si = si; e.sq = sq; e.ov = ov;
    q_main.push_back(e);
  endtask

  task automatic push_sat(input longint si, input longint sq, input logic ov);
    exp_t e;
    e.si = si; e.sq = sq; e.ov = ov;
    q_sat.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One strobed chip, consumed on the next rising edge.
  task automatic chip(input logic p, input int si, input int sq);
    pn     = p;
    i_in   = 16'(si);
    q_in   = 16'(sq);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  // Monitor for the default-width instance.
  always @(negedge clk) begin
    if (valid) begin
      if (q_main.size() == 0) begin
        check("main unexpected valid_o", 1, 0);
      end else begin
        exp_t e;
        e = q_main.pop_front();
        check("main sum_i_o", longint'(sum_i), e.si);
        check("main sum_q_o", longint'(sum_q), e.sq);
        check("main ovf_o", longint'(ovf), longint'(e.ov));
      end
    end
  end

  // Monitor for the narrow-accumulator instance.
  always @(negedge clk) begin
    if (s_valid) begin
      if (q_sat.size() == 0) begin
        check("sat unexpected valid_o", 1, 0);
      end else begin
        exp_t e;
        e = q_sat.pop_front();
        check("sat sum_i_o", longint'(s_sum_i), e.si);
        check("sat sum_q_o", longint'(s_sum_q), e.sq);
        check("sat ovf_o", longint'(s_ovf), longint'(e.ov));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; ena_s = 1'b0; strobe = 1'b0; pn = 1'b0;
    len = 16'd3; i_in = '0; q_in = '0;

    // Reset state, before any clock edge.
    #2;
    check("reset sum_i_o", longint'(sum_i), 0);
    check("reset sum_q_o", longint'(sum_q), 0);
    check("reset valid_o", longint'(valid), 0);
    check("reset busy_o", longint'(busy), 0);
    check("reset ovf_o", longint'(ovf), 0);
    idle(2);
    rst_n = 1'b1;
    tick();
    check("idle busy_o after release", longint'(busy), 0);

    // Entry edge with a coinciding strobe that must be ignored.
    ena = 1'b1; strobe = 1'b1; pn = 1'b1; i_in = 16'sd1000; q_in = 16'sd1000;
    tick();
    strobe = 1'b0;
    check("busy_o in ACCUM", longint'(busy), 1);

    // N=4, all +1 chips; then a back-to-back period of -1 chips.
    push_main(400, -20, 1'b0);
    for (int k = 0; k < 4; k++) chip(1'b1, 100, -5);
    push_main(-12, -28, 1'b0);
    for (int k = 0; k < 4; k++) chip(1'b0, 3, 7);
    idle(3);
    check("hold sum_i_o", longint'(sum_i), -12);
    check("hold sum_q_o", longint'(sum_q), -28);
    check("valid_o low between results", longint'(valid), 0);

    // Sparse strobes (every 3rd cycle) with mixed PN patterns.
    push_main(0, 0, 1'b0);
    push_main(0, 0, 1'b0);
    push_main(-28, -4, 1'b0);
    chip(1'b1, 10, 1); idle(2); chip(1'b0, 10, 1); idle(2);
    chip(1'b1, 10, 1); idle(2); chip(1'b0, 10, 1); idle(2);
    chip(1'b1, 7, 1);  idle(2); chip(1'b1, 7, 1);  idle(2);
    chip(1'b0, 7, 1);  idle(2); chip(1'b0, 7, 1);  idle(2);
    for (int k = 0; k < 4; k++) begin chip(1'b0, 7, 1); idle(2); end

    // Length change mid-period only applies from the next period.
    push_main(10, 0, 1'b0);
    chip(1'b1, 1, 0); chip(1'b1, 2, 0);
    len = 16'd1;
    chip(1'b1, 3, 0); chip(1'b1, 4, 0);
    push_main(11, 0, 1'b0);
    chip(1'b1, 5, 0);
    len = 16'd0;
    chip(1'b1, 6, 0);

    // N=1 with the most negative sample: exact negation, no overflow.
    for (int k = 0; k < 4; k++) push_main(32768, 32768, 1'b0);
    for (int k = 0; k < 4; k++) chip(1'b0, -32768, -32768);
    idle(2);

    // Disable mid-period discards the partial sum.
    len = 16'd7;
    ena = 1'b0;
    tick();
    check("disable clears sum_i_o", longint'(sum_i), 0);
    check("disable clears busy_o", longint'(busy), 0);
    ena = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) chip(1'b1, 50, 50);
    ena = 1'b0;
    tick();
    ena = 1'b1;
    tick();
    push_main(8, 0, 1'b0);
    for (int k = 0; k < 8; k++) chip(1'b1, 1, 0);
    idle(2);
    check("sum_i_o after re-enable", longint'(sum_i), 8);

    // Asynchronous reset between edges, mid-period.
    for (int k = 0; k < 3; k++) chip(1'b1, 2, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset sum_i_o", longint'(sum_i), 0);
    check("async reset busy_o", longint'(busy), 0);
    check("async reset valid_o", longint'(valid), 0);
    check("async reset ovf_o", longint'(ovf), 0);
    tick();
    rst_n = 1'b1;
    tick();
    push_main(16, 0, 1'b0);
    for (int k = 0; k < 8; k++) chip(1'b1, 2, 0);
    idle(2);

    // Saturation on the 17-bit accumulator instance.
    ena = 1'b0;
    tick();
    len = 16'd7;
    ena_s = 1'b1;
    tick();
    push_sat(65535, -65536, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chip(1'b1, 32767, -32768);
      if (k == 1) check("sat ovf_o before clamp", longint'(s_ovf), 0);
      if (k == 2) check("sat ovf_o at clamp", longint'(s_ovf), 1);
    end
    idle(2);
    check("sat ovf_o sticky", longint'(s_ovf), 1);
    check("sat sum_i_o clamped", longint'(s_sum_i), 65535);
    ena_s = 1'b0;
    tick();
    check("sat ovf_o cleared by disable", longint'(s_ovf), 0);
    check("sat busy_o cleared by disable", longint'(s_busy), 0);

    idle(3);
    check("main results outstanding", longint'(q_main.size()), 0);
    check("sat results outstanding", longint'(q_sat.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pn_correlator.md
PN_CORRELATOR -- requirements
Module: pn_correlator

Interface
REQ-001 Parameter: width, 16, signed sample width of i_i/q_i.
REQ-002 Parameter: acc_width, 32, signed accumulator and output width; acc_width SHALL be greater than width.
REQ-003 Parameter: len_width, 16, width of the period-length input.
REQ-004 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n_i  input  1  asynchronous, active-low reset.
REQ-006 ena_i  input  1  block enable; low = synchronous clear to IDLE.
REQ-007 strobe_i  input  1  chip/sample strobe; one chip consumed per cycle it is high.
REQ-008 pn_i  input  1  local PN chip from the upstream LFSR; 1 = +1, 0 = -1.
REQ-009 len_i  input  len_width  chips per correlation period minus one (N-1).
REQ-010 i_i  input  width  signed in-phase sample, valid when strobe_i high.
REQ-011 q_i  input  width  signed quadrature sample, valid when strobe_i high.
REQ-012 sum_i_o  output  acc_width  signed I correlation result of last completed period.
REQ-013 sum_q_o  output  acc_width  signed Q correlation result of last completed period.
REQ-014 valid_o  output  1  one-cycle pulse marking new sum_i_o/sum_q_o.
REQ-015 busy_o  output  1  high while in ACCUM.
REQ-016 ovf_o  output  1  sticky saturation flag.

Function
REQ-017 The block SHALL have two states: IDLE and ACCUM.
REQ-018 IDLE -> ACCUM on the first edge with ena_i high; accumulators, chip counter cleared and len_i latched on that edge; a strobe_i coinciding with that edge SHALL be ignored.
REQ-019 ACCUM -> IDLE on any edge with ena_i low, discarding the partial period: accumulators/counter cleared, valid_o low, sum outputs and ovf_o cleared.
REQ-020 In ACCUM, on each strobe_i edge: acc_i += pn_i ? i_i : -i_i, likewise acc_q with q_i; samples sign-extended to acc_width before negation so -2^(width-1) negates exactly.
REQ-021 Chip counter SHALL increment per strobe_i in ACCUM; cycles without strobe_i SHALL leave accumulators and counter unchanged.
REQ-022 On the strobe_i edge where counter equals latched length: sum_i_o/sum_q_o SHALL load the accumulation including that chip, accumulators and counter clear, len_i re-latched, state stays ACCUM.
REQ-023 valid_o SHALL be high exactly the cycle after the final-chip strobe edge (latency 1 cycle), low otherwise.
REQ-024 A strobe_i in the cycle valid_o is high SHALL be accumulated as chip 0 of the next period; back-to-back strobes lose no chip.
REQ-025 len_i = 0 SHALL give N = 1: every strobe produces a result equal to ±sample.
REQ-026 len_i changes mid-period SHALL take effect only at the next period boundary.
REQ-027 Accumulators SHALL saturate at +2^(acc_width-1)-1 / -2^(acc_width-1); saturation sets ovf_o, which stays high until reset or ena_i low.
REQ-028 sum_i_o/sum_q_o SHALL hold their value between valid_o pulses.

Reset
REQ-029 rst_n_i low SHALL immediately force IDLE, accumulators/counter = 0, sum_i_o = sum_q_o = 0, valid_o = busy_o = ovf_o = 0, independent of clk_i.
REQ-030 Reset release SHALL behave as IDLE with ena_i sampled on the following edges per REQ-018.
REQ-031 Reset asserted mid-period SHALL discard the partial period with no valid_o pulse.

Verification
REQ-032 len_i=3, pn=1,1,1,1, i_i=100, q_i=-5, strobe every cycle -> valid_o pulse 1 cycle after 4th strobe, sum_i_o=400, sum_q_o=-20.
REQ-033 len_i=3, pn=1,0,1,0, i_i=10 constant, strobe every 3rd cycle -> sum_i_o=0; next period with pn=1,1,0,0, i_i=7 -> sum_i_o=0, 4 strobes later pn all 0 -> sum_i_o=-28.
REQ-034 len_i=0, continuous strobes, i_i=-32768, pn=0 -> valid_o high every cycle after first strobe, sum_i_o=+32768, ovf_o=0.
REQ-035 acc_width=17, width=16, len_i=7, i_i=32767, pn=1 -> accumulator clamps at 65535, ovf_o=1 and held; ena_i low one cycle -> ovf_o=0, busy_o=0.
REQ-036 len_i=7, drop ena_i after 5 strobes, re-raise -> no valid_o; next 8 strobes of i_i=1, pn=1 -> sum_i_o=8.
REQ-037 rst_n_i pulsed low between edges mid-period -> all outputs 0 asynchronously, no valid_o after release until a full N-chip period completes.
